pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: turns a configured kernel job into per-step activation strobes for one PE.
// Optional FIFO-full stall counter is built only when PE_SEQ_STALL_CNT_EN is defined.
module pe_seq_ctrl #(
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       cfg_mode,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic [ROW_W-1:0] cfg_rows,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             w_load,
  input  logic             act_valid,
  input  logic [7:0]       act_data,
  output logic             act_ready,
  output logic [7:0]       pe_act,
  output logic [2:0]       pe_state,
  output logic [2:0]       pe_weight_mode,
  output logic             pe_finish,
  output logic             pe_end_of_row,
  input  logic             pe_fifo_full,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned MODE_W = 3;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [MODE_W-1:0] MODE_E   = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(4);
  localparam logic [STEP_W-1:0] K_E      = STEP_W'(3);
  localparam logic [STEP_W-1:0] K_ABCD   = STEP_W'(6);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_WAIT_W = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [COL_W-1:0]    r_cols;
  logic [ROW_W-1:0]    r_rows;
  logic [STEP_W-1:0]   r_step;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_err;
  logic                r_w_load;
  logic [DATA_W-1:0]   r_pe_act;
  logic [STEP_W-1:0]   r_pe_state;
  logic [MODE_W-1:0]   r_pe_weight_mode;
  logic                r_pe_finish;
  logic                r_pe_eor;

  logic                w_cfg_ok;
  logic                w_start_ok;
  logic                w_hs;
  logic [STEP_W-1:0]   w_k;
  logic                w_last_step;
  logic                w_last_col;
  logic                w_last_row;

  assign w_cfg_ok    = (cfg_cols != '0) && (cfg_rows != '0) && (cfg_mode <= MODE_MAX);
  assign w_start_ok  = (r_state == S_IDLE) && start && !abort && w_cfg_ok;
  assign act_ready   = (r_state == S_RUN) && !pe_fifo_full;
  // abort outranks a handshake landing on the same edge
  assign w_hs        = act_valid && act_ready && !abort;
  assign w_k         = (r_mode == MODE_E) ? K_E : K_ABCD;
  assign w_last_step = (r_step == w_k);
  assign w_last_col  = (r_col == COL_W'(r_cols - COL_W'(1)));
  assign w_last_row  = (r_row == ROW_W'(r_rows - ROW_W'(1)));

  // Job FSM with registered strobes and PE-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_mode           <= '0;
      r_cols           <= '0;
      r_rows           <= '0;
      r_step           <= '0;
      r_col            <= '0;
      r_row            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_cfg_err        <= 1'b0;
      r_w_load         <= 1'b0;
      r_pe_act         <= '0;
      r_pe_state       <= '0;
      r_pe_weight_mode <= '0;
      r_pe_finish      <= 1'b0;
      r_pe_eor         <= 1'b0;
    end else begin
      r_done           <= 1'b0;
      r_cfg_err        <= 1'b0;
      r_w_load         <= 1'b0;
      r_pe_state       <= '0;
      r_pe_finish      <= 1'b0;
      r_pe_eor         <= 1'b0;
      r_pe_weight_mode <= r_mode;
      if (abort && (r_state != S_IDLE)) begin
        r_state          <= S_IDLE;
        r_busy           <= 1'b0;
        r_mode           <= '0;
        r_step           <= '0;
        r_col            <= '0;
        r_row            <= '0;
        r_pe_act         <= '0;
        r_pe_weight_mode <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              if (w_cfg_ok) begin
                r_mode   <= cfg_mode;
                r_cols   <= cfg_cols;
                r_rows   <= cfg_rows;
                r_step   <= STEP_W'(1);
                r_col    <= '0;
                r_row    <= '0;
                r_busy   <= 1'b1;
                r_w_load <= 1'b1;
                r_state  <= S_LOAD_W;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          S_LOAD_W: r_state <= S_WAIT_W;
          // one cycle for the PE weight register to settle
          S_WAIT_W: r_state <= S_RUN;
          S_RUN: begin
            if (w_hs) begin
              r_pe_act    <= act_data;
              r_pe_state  <= r_step;
              r_pe_finish <= w_last_step;
              r_pe_eor    <= w_last_step && w_last_col;
              if (w_last_step) begin
                r_step <= STEP_W'(1);
                if (w_last_col) begin
                  r_col <= '0;
                  if (w_last_row) begin
                    r_row   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                  end else begin
                    r_row <= r_row + ROW_W'(1);
                  end
                end else begin
                  r_col <= r_col + COL_W'(1);
                end
              end else begin
                r_step <= r_step + STEP_W'(1);
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign cfg_err        = r_cfg_err;
  assign w_load         = r_w_load;
  assign pe_act         = r_pe_act;
  assign pe_state       = r_pe_state;
  assign pe_weight_mode = r_pe_weight_mode;
  assign pe_finish      = r_pe_finish;
  assign pe_end_of_row  = r_pe_eor;

`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of RUN cycles spent behind a full psum FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && pe_fifo_full && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: job sequences, stalls, abort, bad config and reset.
// Stall-count expectations follow PE_SEQ_STALL_CNT_EN.
module tb_pe_seq_ctrl;

`ifdef PE_SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  cfg_mode;
  logic [7:0]  cfg_cols;
  logic [7:0]  cfg_rows;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        w_load;
  logic        act_valid;
  logic [7:0]  act_data;
  logic        act_ready;
  logic [7:0]  pe_act;
  logic [2:0]  pe_state;
  logic [2:0]  pe_weight_mode;
  logic        pe_finish;
  logic        pe_end_of_row;
  logic        pe_fifo_full;
  logic [15:0] stall_cnt;

  pe_seq_ctrl #(.COL_W(8), .ROW_W(8)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_mode       (cfg_mode),
    .cfg_cols       (cfg_cols),
    .cfg_rows       (cfg_rows),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .w_load         (w_load),
    .act_valid      (act_valid),
    .act_data       (act_data),
    .act_ready      (act_ready),
    .pe_act         (pe_act),
    .pe_state       (pe_state),
    .pe_weight_mode (pe_weight_mode),
    .pe_finish      (pe_finish),
    .pe_end_of_row  (pe_end_of_row),
    .pe_fifo_full   (pe_fifo_full),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int          st_lo, st_zero, n_out, n_fin, n_eor;
  bit          done_seen, done_after_fin, mode_bad;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] mk(input int st, input bit fin, input bit eor, input int act);
    return {3'(st), fin, eor, 8'(act)};
  endfunction

  // Issue an accepted start, then scramble cfg to show it is ignored mid-job
  task automatic drive_start(input string tag, input logic [2:0] mode, input logic [7:0] cols,
                             input logic [7:0] rows);
    cfg_mode = mode;
    cfg_cols = cols;
    cfg_rows = rows;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cfg_mode = 3'd7;
    cfg_cols = 8'd0;
    cfg_rows = 8'd0;
    check({tag, "_wload"}, w_load, 1);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Run until done, recording every non-idle PE output; optional FIFO-full window
  task automatic run_job(input string tag, input logic [2:0] mode, input int stall_at,
                         input int stall_len, input int max_cyc, input bit cmp_seq);
    int nhs = 0;
    int rem = stall_len;
    bit hs, full_now, prev_fin;
    got_q.delete();
    st_lo = 0; st_zero = 0; n_out = 0; n_fin = 0; n_eor = 0;
    done_seen = 0; done_after_fin = 0; mode_bad = 0;
    for (int c = 0; c < max_cyc; c++) begin
      full_now = (nhs == stall_at) && (rem > 0);
      if (full_now) rem--;
      pe_fifo_full = full_now;
      #1;
      hs = act_valid && act_ready;
      if (full_now && !act_ready) st_lo++;
      prev_fin = pe_finish;
      tick();
      if (hs) begin
        act_data = act_data + 8'd1;
        nhs++;
      end
      if (full_now && (pe_state == 3'd0)) st_zero++;
      if (pe_state != 3'd0) begin
        got_q.push_back({pe_state, pe_finish, pe_end_of_row, pe_act});
        n_out++;
        if (pe_finish) n_fin++;
        if (pe_end_of_row) n_eor++;
        if (pe_weight_mode != mode) mode_bad = 1;
      end
      if (done) begin
        done_seen      = 1;
        done_after_fin = prev_fin;
        break;
      end
    end
    pe_fifo_full = 1'b0;
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_done_lat"}, done_after_fin, 1);
    check({tag, "_mode"}, mode_bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    if (cmp_seq) begin
      check({tag, "_nout"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    end
    tick();
    check({tag, "_done_clr"}, done, 0);
  endtask

  task automatic cfg_bad(input string tag, input logic [2:0] mode, input logic [7:0] cols,
                         input logic [7:0] rows);
    cfg_mode = mode;
    cfg_cols = cols;
    cfg_rows = rows;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wload"}, w_load, 0);
    tick();
    check({tag, "_err_clr"}, cfg_err, 0);
    check({tag, "_busy2"}, busy, 0);
    check({tag, "_wload2"}, w_load, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_any;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_mode = '0; cfg_cols = '0; cfg_rows = '0;
    act_valid = 1'b0; act_data = '0; pe_fifo_full = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_wload", w_load, 0);
    check("rst_ready", act_ready, 0);
    check("rst_state", pe_state, 0);
    check("rst_act", pe_act, 0);
    check("rst_wmode", pe_weight_mode, 0);
    check("rst_fin", pe_finish, 0);
    check("rst_eor", pe_end_of_row, 0);
    check("rst_stall", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    act_valid = 1'b1;

    // Mode E, 2 columns, 1 row
    drive_start("e21", 3'd0, 8'd2, 8'd1);
    act_data = 8'h40;
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 8'h40));
    exp_q.push_back(mk(2, 0, 0, 8'h41));
    exp_q.push_back(mk(3, 1, 0, 8'h42));
    exp_q.push_back(mk(1, 0, 0, 8'h43));
    exp_q.push_back(mk(2, 0, 0, 8'h44));
    exp_q.push_back(mk(3, 1, 1, 8'h45));
    run_job("e21", 3'd0, -1, 0, 50, 1);

    // Mode C, 1 column, 2 rows
    drive_start("c12", 3'd3, 8'd1, 8'd2);
    act_data = 8'h80;
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 1; s <= 6; s++)
        exp_q.push_back(mk(s, s == 6, s == 6, 8'h80 + r * 6 + s - 1));
    run_job("c12", 3'd3, -1, 0, 50, 1);

    // Mode A with FIFO full for 4 cycles after step 3
    drive_start("a_stall", 3'd1, 8'd1, 8'd1);
    act_data = 8'h00;
    exp_q.delete();
    for (int s = 1; s <= 6; s++) exp_q.push_back(mk(s, s == 6, s == 6, s - 1));
    run_job("a_stall", 3'd1, 3, 4, 50, 1);
    check("a_stall_ready_lo", st_lo, 4);
    check("a_stall_state0", st_zero, 4);
    check("a_stall_cnt", stall_cnt, STALL_EN ? 4 : 0);

    // FIFO full just before the step-K handshake
    drive_start("e_stallk", 3'd0, 8'd1, 8'd1);
    act_data = 8'hA0;
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 8'hA0));
    exp_q.push_back(mk(2, 0, 0, 8'hA1));
    exp_q.push_back(mk(3, 1, 1, 8'hA2));
    run_job("e_stallk", 3'd0, 2, 2, 50, 1);
    check("e_stallk_ready_lo", st_lo, 2);
    check("e_stallk_cnt", stall_cnt, STALL_EN ? 2 : 0);

    // Abort at step 3 of mode B, with a handshake pending on the same edge
    drive_start("abt", 3'd2, 8'd2, 8'd1);
    act_data = 8'h55;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pe_state == 3'd3) break;
    end
    check("abt_reach3", pe_state, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_busy", busy, 0);
    check("abt_ready", act_ready, 0);
    check("abt_state", pe_state, 0);
    check("abt_act", pe_act, 0);
    check("abt_wmode", pe_weight_mode, 0);
    done_any = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_any = 1'b1;
      tick();
    end
    check("abt_no_done", done_any, 0);
    drive_start("abt_re", 3'd2, 8'd1, 8'd1);
    act_data = 8'h10;
    exp_q.delete();
    for (int s = 1; s <= 6; s++) exp_q.push_back(mk(s, s == 6, s == 6, 8'h10 + s - 1));
    run_job("abt_re", 3'd2, -1, 0, 50, 1);

    // Invalid configurations and start+abort in IDLE
    cfg_bad("bad_cols", 3'd1, 8'd0, 8'd1);
    cfg_bad("bad_mode", 3'd5, 8'd1, 8'd1);
    cfg_bad("bad_rows", 3'd0, 8'd3, 8'd0);
    cfg_mode = 3'd1; cfg_cols = 8'd1; cfg_rows = 8'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_wload", w_load, 0);
    check("sa_err", cfg_err, 0);

    // Maximum column and row counts
    drive_start("maxc", 3'd0, 8'hFF, 8'd1);
    run_job("maxc", 3'd0, -1, 0, 2000, 0);
    check("maxc_nout", n_out, 765);
    check("maxc_nfin", n_fin, 255);
    check("maxc_neor", n_eor, 1);
    drive_start("maxr", 3'd0, 8'd1, 8'hFF);
    run_job("maxr", 3'd0, -1, 0, 2000, 0);
    check("maxr_nout", n_out, 765);
    check("maxr_nfin", n_fin, 255);
    check("maxr_neor", n_eor, 255);

    // Reset asserted mid-RUN, then a fresh job
    drive_start("mr", 3'd4, 8'd2, 8'd1);
    act_data = 8'h77;
    for (int c = 0; c < 5; c++) tick();
    check("mr_running", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_state", pe_state, 0);
    check("mr_act", pe_act, 0);
    check("mr_wmode", pe_weight_mode, 0);
    check("mr_ready", act_ready, 0);
    check("mr_fin", pe_finish, 0);
    check("mr_stall", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("mr_idle", busy, 0);
    drive_start("mr_re", 3'd4, 8'd1, 8'd1);
    act_data = 8'hC0;
    exp_q.delete();
    for (int s = 1; s <= 6; s++) exp_q.push_back(mk(s, s == 6, s == 6, 8'hC0 + s - 1));
    run_job("mr_re", 3'd4, -1, 0, 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
